// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register: holds execute-stage results for the memory stage,
// with stall/flush control, branch decision, EX-hazard forwarding hits and a bubble counter.
module ex_mem_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [1:0]        wb_ctl_in,
  input  logic [2:0]        m_ctl_in,
  input  logic [DATA_W-1:0] branch_tgt_in,
  input  logic              zero_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] rdata2_in,
  input  logic [REG_AW-1:0] wreg_in,
  input  logic [REG_AW-1:0] id_ex_rs,
  input  logic [REG_AW-1:0] id_ex_rt,
  output logic              valid_out,
  output logic [1:0]        wb_ctl_out,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] branch_tgt_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] rdata2_out,
  output logic [REG_AW-1:0] wreg_out,
  output logic              pc_src,
  output logic              fwd_a_hit,
  output logic              fwd_b_hit,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic [2:0]       m_ctl_q;
  logic             zero_q;
  logic [CNT_W-1:0] bubble_next;

  // Counter sticks at all-ones so a long idle period cannot wrap it back to a small value.
  assign bubble_next = (bubble_cnt == '1) ? bubble_cnt : bubble_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out      <= 1'b0;
      wb_ctl_out     <= '0;
      m_ctl_q        <= '0;
      zero_q         <= 1'b0;
      branch_tgt_out <= '0;
      alu_result_out <= '0;
      rdata2_out     <= '0;
      wreg_out       <= '0;
      bubble_cnt     <= '0;
    end else if (flush) begin
      valid_out      <= 1'b0;
      wb_ctl_out     <= '0;
      m_ctl_q        <= '0;
      zero_q         <= 1'b0;
      branch_tgt_out <= '0;
      alu_result_out <= '0;
      rdata2_out     <= '0;
      wreg_out       <= '0;
      bubble_cnt     <= bubble_next;
    end else if (!stall) begin
      // Control bits of a non-instruction are dropped so a bubble can never write.
      valid_out      <= in_valid;
      wb_ctl_out     <= in_valid ? wb_ctl_in : 2'b00;
      m_ctl_q        <= in_valid ? m_ctl_in : 3'b000;
      zero_q         <= zero_in;
      branch_tgt_out <= branch_tgt_in;
      alu_result_out <= alu_result_in;
      rdata2_out     <= rdata2_in;
      wreg_out       <= wreg_in;
      if (!in_valid) begin
        bubble_cnt <= bubble_next;
      end
    end
  end

  assign mem_read  = valid_out & m_ctl_q[1];
  assign mem_write = valid_out & m_ctl_q[0];
  assign pc_src    = valid_out & m_ctl_q[2] & zero_q;

  // Register 0 is hardwired, so a write to it must never be forwarded.
  assign fwd_a_hit = valid_out & wb_ctl_out[1] & (wreg_out != '0) & (wreg_out == id_ex_rs);
  assign fwd_b_hit = valid_out & wb_ctl_out[1] & (wreg_out != '0) & (wreg_out == id_ex_rt);

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Randomized scoreboard bench for ex_mem_pipe_reg: a content-level model predicts the
// stage after every edge, and an independent monitor compares one cycle later.
module tb_ex_mem_pipe_reg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst;
  logic              stall;
  logic              flush;
  logic              in_valid;
  logic [1:0]        wb_ctl_in;
  logic [2:0]        m_ctl_in;
  logic [DATA_W-1:0] branch_tgt_in;
  logic              zero_in;
  logic [DATA_W-1:0] alu_result_in;
  logic [DATA_W-1:0] rdata2_in;
  logic [REG_AW-1:0] wreg_in;
  logic [REG_AW-1:0] id_ex_rs;
  logic [REG_AW-1:0] id_ex_rt;
  logic              valid_out;
  logic [1:0]        wb_ctl_out;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] branch_tgt_out;
  logic [DATA_W-1:0] alu_result_out;
  logic [DATA_W-1:0] rdata2_out;
  logic [REG_AW-1:0] wreg_out;
  logic              pc_src;
  logic              fwd_a_hit;
  logic              fwd_b_hit;
  logic [CNT_W-1:0]  bubble_cnt;

  ex_mem_pipe_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .wb_ctl_in(wb_ctl_in), .m_ctl_in(m_ctl_in), .branch_tgt_in(branch_tgt_in),
    .zero_in(zero_in), .alu_result_in(alu_result_in), .rdata2_in(rdata2_in),
    .wreg_in(wreg_in), .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt),
    .valid_out(valid_out), .wb_ctl_out(wb_ctl_out), .mem_read(mem_read),
    .mem_write(mem_write), .branch_tgt_out(branch_tgt_out),
    .alu_result_out(alu_result_out), .rdata2_out(rdata2_out), .wreg_out(wreg_out),
    .pc_src(pc_src), .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit),
    .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic              valid;
    logic [1:0]        wb;
    logic              mr;
    logic              mw;
    logic              pc;
    logic              fa;
    logic              fb;
    logic [DATA_W-1:0] tgt;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rd2;
    logic [REG_AW-1:0] wreg;
    logic [CNT_W-1:0]  cnt;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  // Reference model: what instruction (if any) the stage holds, plus the bubble tally.
  logic              m_valid;
  logic [1:0]        m_wb;
  logic              m_branch, m_read, m_write, m_zero;
  logic [DATA_W-1:0] m_tgt, m_alu, m_rd2;
  logic [REG_AW-1:0] m_wreg;
  int                m_bubbles;

  logic              r_rst, r_stall, r_flush, r_valid, r_zero;
  logic [1:0]        r_wb;
  logic [2:0]        r_m;
  logic [DATA_W-1:0] r_tgt, r_alu, r_rd2;
  logic [REG_AW-1:0] r_wreg, r_rs, r_rt;

  task automatic clearStage();
    m_valid = 0; m_wb = 0; m_branch = 0; m_read = 0; m_write = 0; m_zero = 0;
    m_tgt = 0; m_alu = 0; m_rd2 = 0; m_wreg = 0;
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic f, input logic v,
                               input logic [1:0] wb, input logic [2:0] m,
                               input logic [DATA_W-1:0] tgt, input logic z,
                               input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] rd2,
                               input logic [REG_AW-1:0] wr, input logic [REG_AW-1:0] rs,
                               input logic [REG_AW-1:0] rt);
    exp_t e;
    @(negedge clk);
    rst = r; stall = s; flush = f; in_valid = v; wb_ctl_in = wb; m_ctl_in = m;
    branch_tgt_in = tgt; zero_in = z; alu_result_in = alu; rdata2_in = rd2;
    wreg_in = wr; id_ex_rs = rs; id_ex_rt = rt;
    if (r) begin
      clearStage();
      m_bubbles = 0;
    end else if (f) begin
      clearStage();
      m_bubbles = m_bubbles + 1;
    end else if (!s) begin
      m_valid = v;
      m_wb = v ? wb : 2'b00;
      m_branch = v && m[2];
      m_read = v && m[1];
      m_write = v && m[0];
      m_zero = z; m_tgt = tgt; m_alu = alu; m_rd2 = rd2; m_wreg = wr;
      if (!v) m_bubbles = m_bubbles + 1;
    end
    if (m_bubbles > CNT_MAX) m_bubbles = CNT_MAX;
    e.valid = m_valid;
    e.wb    = m_wb;
    e.mr    = m_valid && m_read;
    e.mw    = m_valid && m_write;
    e.pc    = m_valid && m_branch && m_zero;
    e.fa    = m_valid && m_wb[1] && (m_wreg != 0) && (m_wreg == rs);
    e.fb    = m_valid && m_wb[1] && (m_wreg != 0) && (m_wreg == rt);
    e.tgt   = m_tgt;
    e.alu   = m_alu;
    e.rd2   = m_rd2;
    e.wreg  = m_wreg;
    e.cnt   = CNT_W'(m_bubbles);
    expq.push_back(e);
  endtask

  task automatic cmp(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL cycle %0d %s: got %h expected %h", cycle, name, act, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    e = expq.pop_front();
    cmp("valid_out", DATA_W'(valid_out), DATA_W'(e.valid));
    cmp("wb_ctl_out", DATA_W'(wb_ctl_out), DATA_W'(e.wb));
    cmp("mem_read", DATA_W'(mem_read), DATA_W'(e.mr));
    cmp("mem_write", DATA_W'(mem_write), DATA_W'(e.mw));
    cmp("pc_src", DATA_W'(pc_src), DATA_W'(e.pc));
    cmp("fwd_a_hit", DATA_W'(fwd_a_hit), DATA_W'(e.fa));
    cmp("fwd_b_hit", DATA_W'(fwd_b_hit), DATA_W'(e.fb));
    cmp("branch_tgt_out", branch_tgt_out, e.tgt);
    cmp("alu_result_out", alu_result_out, e.alu);
    cmp("rdata2_out", rdata2_out, e.rd2);
    cmp("wreg_out", DATA_W'(wreg_out), DATA_W'(e.wreg));
    cmp("bubble_cnt", DATA_W'(bubble_cnt), DATA_W'(e.cnt));
  endtask

  // Monitor: the stage presents a new result every cycle, sampled just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (expq.size() > 0) checkOutput();
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1; stall = 0; flush = 0; in_valid = 0; wb_ctl_in = 0; m_ctl_in = 0;
    branch_tgt_in = 0; zero_in = 0; alu_result_in = 0; rdata2_in = 0;
    wreg_in = 0; id_ex_rs = 0; id_ex_rt = 0;
    clearStage();
    m_bubbles = 0;

    applyStimulus(1, 0, 0, 1, 2'b11, 3'b111, 32'hdead_beef, 1, 32'h1234, 32'h5678, 5'd3, 5'd3, 5'd3);
    applyStimulus(1, 1, 1, 1, 2'b11, 3'b111, 32'hdead_beef, 1, 32'h1234, 32'h5678, 5'd3, 5'd3, 5'd3);
    applyStimulus(0, 0, 0, 0, 2'b00, 3'b000, 32'h0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);

    applyStimulus(0, 0, 0, 1, 2'b10, 3'b000, 32'h0, 0, 32'h0000_0010, 32'h0, 5'd8, 5'd8, 5'd9);
    applyStimulus(0, 0, 0, 1, 2'b10, 3'b000, 32'h0, 0, 32'h0000_0010, 32'h0, 5'd0, 5'd0, 5'd9);

    applyStimulus(0, 0, 0, 1, 2'b00, 3'b100, 32'h40, 1, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 1, 2'b11, 3'b011, $urandom, 0, $urandom, $urandom,
                    5'($urandom_range(1, 31)), 5'd0, 5'd0);
    end
    applyStimulus(0, 1, 1, 1, 2'b10, 3'b001, 32'h80, 1, 32'h99, 32'h77, 5'd4, 5'd4, 5'd4);

    for (int i = 0; i < 300; i++) begin
      r_rst   = ($urandom_range(0, 49) == 0);
      r_stall = ($urandom_range(0, 4) == 0);
      r_flush = ($urandom_range(0, 7) == 0);
      r_valid = ($urandom_range(0, 3) != 0);
      r_wb    = 2'($urandom);
      r_m     = 3'($urandom);
      r_tgt   = $urandom;
      r_zero  = 1'($urandom);
      r_alu   = $urandom;
      r_rd2   = $urandom;
      r_wreg  = 5'($urandom_range(0, 3));
      r_rs    = 5'($urandom_range(0, 3));
      r_rt    = 5'($urandom_range(0, 3));
      applyStimulus(r_rst, r_stall, r_flush, r_valid, r_wb, r_m, r_tgt, r_zero,
                    r_alu, r_rd2, r_wreg, r_rs, r_rt);
    end

    applyStimulus(1, 0, 0, 0, 2'b00, 3'b000, 32'h0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < CNT_MAX + 4; i++) begin
      applyStimulus(0, 0, 0, 0, 2'($urandom), 3'($urandom), $urandom, 1'($urandom),
                    $urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom));
    end

    repeat (2) @(posedge clk);
    #3;
    cmp("scoreboard_drained", DATA_W'(expq.size()), DATA_W'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe_reg.md
Name: ex_mem_pipe_reg

Overview:
EX/MEM pipeline register sitting directly downstream of the execute stage. It captures the ALU result, store data, branch target, zero flag, the 5-bit destination register chosen by the execute-stage RegDst mux, and the WB/M control bits. It supports stall (hold) and flush (bubble insertion), and produces the MEM-stage branch decision and EX-hazard forwarding hits for the execute stage. It also keeps a saturating count of bubbles inserted for debug.

Parameters:
DATA_W, 32, width of ALU result, store data and branch target
REG_AW, 5, width of register address
CNT_W, 16, width of bubble counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
stall  input  1  hold all stage contents this cycle
flush  input  1  load a bubble this cycle
in_valid  input  1  execute stage holds a real instruction
wb_ctl_in  input  2  {RegWrite, MemtoReg}
m_ctl_in  input  3  {Branch, MemRead, MemWrite}
branch_tgt_in  input  DATA_W  branch target from execute adder
zero_in  input  1  ALU zero flag
alu_result_in  input  DATA_W  ALU result
rdata2_in  input  DATA_W  store data (rt value)
wreg_in  input  REG_AW  destination register from the execute-stage RegDst mux
id_ex_rs  input  REG_AW  rs of the instruction currently in execute
id_ex_rt  input  REG_AW  rt of the instruction currently in execute
valid_out  output  1  stage holds a real instruction
wb_ctl_out  output  2  registered WB control
mem_read  output  1  registered MemRead, gated by valid
mem_write  output  1  registered MemWrite, gated by valid
branch_tgt_out  output  DATA_W  registered branch target
alu_result_out  output  DATA_W  registered ALU result; memory address
rdata2_out  output  DATA_W  registered store data
wreg_out  output  REG_AW  registered destination register
pc_src  output  1  take branch: valid & Branch & zero (combinational on registered state)
fwd_a_hit  output  1  forward ALU result to execute operand A
fwd_b_hit  output  1  forward ALU result to execute operand B
bubble_cnt  output  CNT_W  number of bubbles inserted, saturating

Behaviour:
- Priority on each rising edge: rst, then flush, then stall, then normal load.
- rst: all registered outputs 0, valid_out=0, bubble_cnt=0. Combinational outputs are therefore 0.
- flush: valid_out=0; wb_ctl, m_ctl, zero, data and wreg all cleared to 0. bubble_cnt increments. flush overrides a simultaneous stall.
- stall (no flush): every register holds its value. bubble_cnt is unchanged.
- Normal load: every register captures its *_in value; valid_out<=in_valid.
  - If in_valid=0, wb_ctl and m_ctl are stored as 0, so a bubble can never write. bubble_cnt increments.
- Latency: exactly 1 cycle from input to registered output. No combinational path from *_in to any output.
- mem_read and mem_write equal the stored m_ctl bit AND valid_out.
- pc_src = valid_out & Branch & zero.
- fwd_a_hit = valid_out & RegWrite & (wreg_out != 0) & (wreg_out == id_ex_rs). fwd_b_hit uses id_ex_rt in the same way. Register 0 never forwards.
- bubble_cnt saturates at all-ones and never wraps.
- Reset asserted mid-stall or mid-flush: reset wins, and state is cleared on that edge.
- No internal state machine beyond the valid bit and the counter. Behaviour is fully determined by the priority rules above.

Test Plan:
- rst=1 for 2 cycles, then release with stall=flush=0 and in_valid=0 -> all outputs 0; bubble_cnt=1 after the first post-reset edge.
- Load in_valid=1, wb=2'b10, alu=32'h0000_0010, wreg=5'd8; next cycle id_ex_rs=8, id_ex_rt=9 -> outputs match one cycle later; fwd_a_hit=1, fwd_b_hit=0.
- Same load with wreg=0 and id_ex_rs=0 -> fwd_a_hit=0.
- Load m_ctl=3'b100, zero=1, tgt=32'h40, valid -> pc_src=1 and branch_tgt_out=32'h40. Then stall=1 for 3 cycles with changed inputs -> outputs held, bubble_cnt unchanged.
- stall=1 and flush=1 on the same edge with m_ctl=3'b001 -> valid_out=0, mem_write=0, pc_src=0, bubble_cnt+1.
- Force in_valid=0 for 2^CNT_W+3 cycles (run with CNT_W=4: 19 cycles) -> bubble_cnt holds at 4'hF.
